vga_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous frame-buffer RAM between the VGA scan-out

---
 rtl/vga_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_vga_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_mem_arbiter
//  Purpose  : Shares a single-port synchronous frame-buffer RAM between the
//             VGA scan-out reader (absolute priority, never stalled) and a
//             pixel writer. Writes are queued in a small FIFO and drained in
//             cycles where the reader is idle (blanking).
//  Revision : 1.0 - initial release
// ============================================================================
module vga_mem_arbiter #(
  parameter int AW         = 19,
  parameter int DW         = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic               clk,
  input  logic               rstn,
  // scan-out reader
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic               rd_valid,
  output logic [DW-1:0]      rd_data,
  // pixel writer
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  // RAM port
  output logic [AW-1:0]      mem_addr,
  output logic               mem_we,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  // status
  output logic [FIFO_AW:0]   fifo_level,
  input  logic               clr_stats,
  output logic [15:0]        stall_cnt
);

  // One FIFO entry carries the address in the upper bits, pixel in the lower.
  localparam int                 c_ew         = AW + DW;
  localparam logic [FIFO_AW:0]   c_full_level = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [15:0]        c_stall_max  = 16'hFFFF;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_ew-1:0]     fifo_q [FIFO_DEPTH];
  logic [c_ew-1:0]     fifo_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    level_q,  level_d;

  logic                rd_pend_q,  rd_pend_d;   // rd_en delayed by one cycle
  logic                rd_valid_q, rd_valid_d;
  logic [DW-1:0]       rd_data_q,  rd_data_d;

  logic [15:0]         stall_q, stall_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic [c_ew-1:0]     w_head;

  // FIFO status and the entry currently at the head.
  always_comb begin
    w_empty = (level_q == '0);
    w_full  = (level_q == c_full_level);
    w_head  = fifo_q[rd_ptr_q];
    w_push  = wr_valid && !w_full;
  end

  // Port grant: reader always wins; a queued write uses the port only when
  // the reader is idle. The head is popped in the same cycle it is written,
  // so an entry pushed this cycle can never reach the RAM before next cycle.
  always_comb begin
    mem_addr  = rd_addr;
    mem_we    = 1'b0;
    mem_wdata = w_head[DW-1:0];
    w_pop     = 1'b0;
    if (!rd_en && !w_empty) begin
      mem_addr = w_head[c_ew-1:DW];
      mem_we   = 1'b1;
      w_pop    = 1'b1;
    end
  end

  // Next-state for the write FIFO: storage, pointers and occupancy.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_push) begin
      fifo_d[wr_ptr_q] = {wr_addr, wr_data};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Next-state for the two-stage read pipeline: address cycle, RAM cycle,
  // then the registered pixel. rd_data keeps its last value between reads.
  always_comb begin
    rd_pend_d  = rd_en;
    rd_valid_d = rd_pend_q;
    rd_data_d  = rd_data_q;
    if (rd_pend_q) begin
      rd_data_d = mem_rdata;
    end
  end

  // Next-state for the saturating writer-stall counter; clear has priority.
  always_comb begin
    stall_d = stall_q;
    if (clr_stats) begin
      stall_d = '0;
    end else if (wr_valid && w_full && (stall_q != c_stall_max)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------

  // FIFO payload storage; contents are meaningless while the level is zero,
  // so it needs no reset.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  // Control state; reset discards every pending write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      stall_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_pend_q  <= rd_pend_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      stall_q    <= stall_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------

  // Drive status and read-side outputs straight from their registers.
  always_comb begin
    wr_ready   = !w_full;
    fifo_level = level_q;
    rd_valid   = rd_valid_q;
    rd_data    = rd_data_q;
    stall_cnt  = stall_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_mem_arbiter
//  Purpose  : Directed, table-driven bench for vga_mem_arbiter with a
//             behavioural single-port RAM (unwritten word reads addr[11:0]).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_mem_arbiter;

  logic        clk;
  logic        rstn;
  logic        rd_en;
  logic [18:0] rd_addr;
  logic        rd_valid;
  logic [11:0] rd_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [4:0]  fifo_level;
  logic        clr_stats;
  logic [15:0] stall_cnt;

  int compared   = 0;
  int mismatched = 0;

  vga_mem_arbiter #(
    .AW(19), .DW(12), .FIFO_DEPTH(16), .FIFO_AW(4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .fifo_level (fifo_level),
    .clr_stats  (clr_stats),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous single-port RAM.
  logic [11:0] ram [int];
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_we) ram[int'(mem_addr)] = mem_wdata;
    else        mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : mem_addr[11:0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write enable and read request must never coincide.
  always @(negedge clk) begin
    if (rstn && rd_en) chk("no_we_during_read", {31'd0, mem_we}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        re;
    logic [18:0] ra;
    logic        wv;
    logic [18:0] wa;
    logic [11:0] wd;
    logic        e_we;
    logic [18:0] e_addr;
    logic [11:0] e_wdata;
    logic [4:0]  e_level;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic re, logic [18:0] ra, logic wv, logic [18:0] wa,
                              logic [11:0] wd, logic e_we, logic [18:0] e_addr,
                              logic [11:0] e_wdata, logic [4:0] e_level, logic e_ready);
    vec_t v;
    v.re = re; v.ra = ra; v.wv = wv; v.wa = wa; v.wd = wd;
    v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_level = e_level; v.e_ready = e_ready;
    vecs.push_back(v);
  endfunction

  initial begin
    int k;
    rstn = 1'b0; rd_en = 1'b0; rd_addr = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; clr_stats = 1'b0;

    // Back-to-back writes with the reader idle: each drains the cycle after
    // it is accepted, so the level never exceeds one.
    //   re ra        wv wa      wd       we addr      wdata   lvl rdy
    add(0, 19'h0ABCD, 1, 19'h0, 12'h00A, 0, 19'h0ABCD, 12'h000, 0, 1);
    add(0, 19'h0ABCD, 1, 19'h1, 12'h00B, 1, 19'h00000, 12'h00A, 1, 1);
    add(0, 19'h0ABCD, 1, 19'h2, 12'h00C, 1, 19'h00001, 12'h00B, 1, 1);
    add(0, 19'h0ABCD, 1, 19'h3, 12'h00D, 1, 19'h00002, 12'h00C, 1, 1);
    add(0, 19'h0ABCD, 0, 19'h0, 12'h000, 1, 19'h00003, 12'h00D, 1, 1);
    add(0, 19'h0ABCD, 0, 19'h0, 12'h000, 0, 19'h0ABCD, 12'h000, 0, 1);
    // Reader busy: five writes queue up, nothing reaches the RAM.
    for (int i = 0; i < 5; i++)
      add(1, 19'h00123, 1, 19'h10 + 19'(i), 12'h100 + 12'(i), 0, 19'h00123, 12'h000, 5'(i), 1);
    // Reader idle with a push: push and pop together, level stays at 5.
    add(0, 19'h00123, 1, 19'h15, 12'h105, 1, 19'h00010, 12'h100, 5, 1);
    add(1, 19'h00123, 0, 19'h0,  12'h000, 0, 19'h00123, 12'h000, 5, 1);
    // Drain the remaining five in acceptance order.
    for (int i = 0; i < 5; i++)
      add(0, 19'h0ABCD, 0, 19'h0, 12'h000, 1, 19'h11 + 19'(i), 12'h101 + 12'(i), 5'(5 - i), 1);
    add(0, 19'h0ABCD, 0, 19'h0, 12'h000, 0, 19'h0ABCD, 12'h000, 0, 1);

    // ---------------- reset values ----------------
    tick(); tick();
    chk("rst_level",    32'(fifo_level), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready),   32'd1);
    chk("rst_rd_valid", 32'(rd_valid),   32'd0);
    chk("rst_rd_data",  32'(rd_data),    32'd0);
    chk("rst_stall",    32'(stall_cnt),  32'd0);
    chk("rst_mem_we",   32'(mem_we),     32'd0);
    rstn = 1'b1;
    tick();

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      rd_en = vecs[i].re; rd_addr = vecs[i].ra;
      wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      @(negedge clk);
      chk($sformatf("vec%0d_we", i),    32'(mem_we),     32'(vecs[i].e_we));
      chk($sformatf("vec%0d_addr", i),  32'(mem_addr),   32'(vecs[i].e_addr));
      if (vecs[i].e_we)
        chk($sformatf("vec%0d_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_wdata));
      chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].e_level));
      chk($sformatf("vec%0d_ready", i), 32'(wr_ready),   32'(vecs[i].e_ready));
      tick();
    end

    // ---------------- read latency with writes pending ----------------
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; rd_addr = 19'h07000;
      wr_valid = 1'b1; wr_addr = 19'h200 + 19'(i); wr_data = 12'hEE0 + 12'(i);
      tick();
    end
    rd_en = 1'b1; rd_addr = 19'h00005; wr_valid = 1'b0;
    @(negedge clk);
    chk("rd_cycle_we",    32'(mem_we),     32'd0);
    chk("rd_cycle_level", 32'(fifo_level), 32'd3);
    chk("rd_cycle_addr",  32'(mem_addr),   32'h5);
    tick();
    rd_en = 1'b0; rd_addr = 19'h0ABCD;
    @(negedge clk);
    chk("rd_n1_valid", 32'(rd_valid), 32'd1);
    chk("rd_n1_data",  32'(rd_data),  32'h000);
    tick();
    @(negedge clk);
    chk("rd_n2_valid", 32'(rd_valid), 32'd1);
    chk("rd_n2_data",  32'(rd_data),  32'h005);
    tick();
    @(negedge clk);
    chk("rd_n3_valid", 32'(rd_valid), 32'd0);
    chk("rd_n3_hold",  32'(rd_data),  32'h005);
    tick(); tick(); tick();
    chk("rd_drained", 32'(fifo_level), 32'd0);

    // ---------------- fill during a 20-cycle read burst ----------------
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      rd_en = 1'b1; rd_addr = 19'h07000;
      wr_valid = 1'b1; wr_addr = 19'h300 + 19'(k); wr_data = 12'h300 + 12'(k);
      @(negedge clk);
      if (c == 15) chk("fill_ready_c16", 32'(wr_ready), 32'd1);
      if (c == 16) chk("fill_ready_c17", 32'(wr_ready), 32'd0);
      if (wr_ready) k++;
      tick();
    end
    chk("fill_accepted", 32'(k),          32'd16);
    chk("fill_level",    32'(fifo_level), 32'd16);
    chk("fill_stall",    32'(stall_cnt),  32'd4);
    rd_en = 1'b0; wr_valid = 1'b0; rd_addr = 19'h0ABCD;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_we", i),    32'(mem_we),    32'd1);
      chk($sformatf("drain%0d_addr", i),  32'(mem_addr),  32'h300 + 32'(i));
      chk($sformatf("drain%0d_wdata", i), 32'(mem_wdata), 32'h300 + 32'(i));
      tick();
    end
    @(negedge clk);
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("drain_we",    32'(mem_we),     32'd0);
    tick();

    // ---------------- stall counter clear and saturation ----------------
    rd_en = 1'b1; rd_addr = 19'h07000; wr_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      wr_addr = 19'h400 + 19'(i); wr_data = 12'h400 + 12'(i);
      tick();
    end
    chk("stall_pre_clr", 32'(stall_cnt), 32'd6);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("stall_clr_wins", 32'(stall_cnt), 32'd0);
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
    repeat (5) tick();
    chk("stall_sat_hold", 32'(stall_cnt), 32'hFFFF);

    // ---------------- asynchronous reset mid-burst ----------------
    rd_en = 1'b0; wr_valid = 1'b0; rd_addr = 19'h0ABCD;
    repeat (9) tick();
    chk("pre_rst_level", 32'(fifo_level), 32'd7);
    wr_valid = 1'b1;
    #1;
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    rstn = 1'b0;
    #1;
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_ready", 32'(wr_ready),   32'd1);
    chk("arst_we",    32'(mem_we),     32'd0);
    chk("arst_stall", 32'(stall_cnt),  32'd0);
    wr_valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_level", 32'(fifo_level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
